alu_multicycle: RTL and testbench

//  Parametrised, clocked successor to the 4-op combinational ALU: 8 ops incl. XOR, shifts, iterative MUL.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_iter.sv | 55 +++++
 rtl/alu_multicycle.sv | 143 ++++++++++++++
 tb/tb_alu_multicycle.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_XOR = 3'b100,
        OP_LSL = 3'b101,
        OP_LSR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } alu_state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks after start.
// done/p are combinational so the caller can capture the final sum on the last step edge.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int unsigned CNTW = $clog2(WIDTH);

    logic             busy;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] accNext;

    // Sum including the current partial product; on the last step this is the product.
    always_comb begin
        accNext = acc + (mplier[0] ? mcand : '0);
        done    = busy && (cnt == CNTW'(WIDTH - 1));
        p       = accNext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= accNext;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNTW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Clocked ALU with valid/ready input: single-cycle logic/arith/shift ops, iterative MUL.
// Result and NZCV flags are registered and held until the next result.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags,
    output logic             out_valid
);

    localparam int unsigned SUMW = WIDTH + 1;

    alu_state_e       state;
    alu_state_e       stateNext;
    alu_op_e          opSel;
    logic             inReadyQ;
    logic             aluWrite;
    logic             mulStart;
    logic             mulWrite;
    logic             mulDone;
    logic [WIDTH-1:0] mulP;
    logic [SHW-1:0]   sh;
    logic             isSub;
    logic [SUMW-1:0]  sum;
    logic [SUMW-1:0]  lslWide;
    logic [SUMW-1:0]  lsrWide;
    logic [WIDTH-1:0] aluRes;
    logic [3:0]       aluFlags;
    logic [3:0]       mulFlags;

    assign opSel    = alu_op_e'(op);
    assign in_ready = inReadyQ;

    alu_mul_iter #(.WIDTH(WIDTH)) uMul (
        .clk   (clk),
        .rst   (rst),
        .start (mulStart),
        .a     (a),
        .b     (b),
        .done  (mulDone),
        .p     (mulP)
    );

    // State register; ready tracks the next state so it is high exactly in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            inReadyQ <= 1'b1;
        end else begin
            state    <= stateNext;
            inReadyQ <= (stateNext == S_IDLE);
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  if (in_valid && opSel == OP_MUL) stateNext = S_MUL;
            S_MUL:   if (mulDone) stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        aluWrite = 1'b0;
        mulStart = 1'b0;
        mulWrite = 1'b0;
        case (state)
            S_IDLE: begin
                mulStart = in_valid && (opSel == OP_MUL);
                aluWrite = in_valid && (opSel != OP_MUL);
            end
            S_MUL:   mulWrite = mulDone;
            default: ;
        endcase
    end

    // Single-cycle datapath; shifts use a spare bit to catch the last bit shifted out.
    always_comb begin
        sh       = b[SHW-1:0];
        isSub    = (opSel == OP_SUB);
        sum      = {1'b0, a} + {1'b0, (isSub ? ~b : b)} + SUMW'(isSub);
        lslWide  = {1'b0, a} << sh;
        lsrWide  = {a, 1'b0} >> sh;
        aluRes   = '0;
        aluFlags = '0;
        case (opSel)
            OP_AND: aluRes = a & b;
            OP_OR:  aluRes = a | b;
            OP_XOR: aluRes = a ^ b;
            OP_ADD, OP_SUB: begin
                aluRes           = sum[WIDTH-1:0];
                aluFlags[FLAG_C] = sum[WIDTH];
                aluFlags[FLAG_V] = ((a[WIDTH-1] == b[WIDTH-1]) ^ isSub)
                                   && (aluRes[WIDTH-1] != a[WIDTH-1]);
            end
            OP_LSL: begin
                aluRes           = lslWide[WIDTH-1:0];
                aluFlags[FLAG_C] = lslWide[WIDTH];
            end
            OP_LSR: begin
                aluRes           = lsrWide[WIDTH:1];
                aluFlags[FLAG_C] = lsrWide[0];
            end
            default: aluRes = '0;
        endcase
        aluFlags[FLAG_N] = aluRes[WIDTH-1];
        aluFlags[FLAG_Z] = (aluRes == '0);
        mulFlags         = '0;
        mulFlags[FLAG_N] = mulP[WIDTH-1];
        mulFlags[FLAG_Z] = (mulP == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y         <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (aluWrite) begin
                y         <= aluRes;
                flags     <= aluFlags;
                out_valid <= 1'b1;
            end else if (mulWrite) begin
                y         <= mulP;
                flags     <= mulFlags;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=8; flags are checked as {N,Z,C,V}.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       inValid;
    logic       inReady;
    logic [7:0] aIn;
    logic [7:0] bIn;
    logic [2:0] opIn;
    logic [7:0] y;
    logic [3:0] flags;
    logic       outValid;

    int errors = 0;
    int checks = 0;

    alu_multicycle #(.WIDTH(8), .SHW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (aIn),
        .b         (bIn),
        .op        (opIn),
        .y         (y),
        .flags     (flags),
        .out_valid (outValid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an op and lets one edge pass; in_valid stays high for the caller to drop.
    task automatic issue(input alu_op_e o, input logic [7:0] aa, input logic [7:0] bb);
        opIn    = o;
        aIn     = aa;
        bIn     = bb;
        inValid = 1'b1;
        step();
    endtask

    task automatic expectResult(input string tag, input logic [7:0] ey, input logic [3:0] ef);
        check({tag, "_ov"}, 8'(outValid), 8'd1);
        check({tag, "_y"}, y, ey);
        check({tag, "_flags"}, 8'(flags), 8'(ef));
    endtask

    initial begin
        rst     = 1'b1;
        inValid = 1'b0;
        aIn     = '0;
        bIn     = '0;
        opIn    = 3'b000;
        #1;
        check("rst_y", y, 8'h00);
        check("rst_flags", 8'(flags), 8'h0);
        check("rst_ov", 8'(outValid), 8'd0);
        check("rst_ready", 8'(inReady), 8'd1);
        step();
        step();
        rst = 1'b0;
        step();

        issue(OP_ADD, 8'h7F, 8'h01);
        inValid = 1'b0;
        expectResult("add_ovf", 8'h80, 4'b1001);
        step();
        check("add_pulse_end", 8'(outValid), 8'd0);
        check("add_hold_y", y, 8'h80);
        check("add_hold_flags", 8'(flags), 8'(4'b1001));

        issue(OP_SUB, 8'h05, 8'h05);
        inValid = 1'b0;
        expectResult("sub_eq", 8'h00, 4'b0110);
        issue(OP_SUB, 8'h00, 8'h01);
        inValid = 1'b0;
        expectResult("sub_borrow", 8'hFF, 4'b1000);
        issue(OP_SUB, 8'h80, 8'h01);
        inValid = 1'b0;
        expectResult("sub_ovf", 8'h7F, 4'b0011);
        issue(OP_AND, 8'hF0, 8'h3C);
        inValid = 1'b0;
        expectResult("and", 8'h30, 4'b0000);
        issue(OP_LSL, 8'h81, 8'h01);
        inValid = 1'b0;
        expectResult("lsl1", 8'h02, 4'b0010);
        issue(OP_LSL, 8'h81, 8'h07);
        inValid = 1'b0;
        expectResult("lsl7", 8'h80, 4'b1000);
        issue(OP_LSL, 8'h81, 8'h09);
        inValid = 1'b0;
        expectResult("lsl_lowbits", 8'h02, 4'b0010);
        issue(OP_LSR, 8'h81, 8'h00);
        inValid = 1'b0;
        expectResult("lsr0", 8'h81, 4'b1000);
        issue(OP_LSR, 8'h81, 8'h01);
        inValid = 1'b0;
        expectResult("lsr1", 8'h40, 4'b0010);
        issue(OP_LSR, 8'h81, 8'h0C);
        inValid = 1'b0;
        expectResult("lsr4", 8'h08, 4'b0000);

        // MUL with stray in_valid pulses that must be ignored while busy.
        issue(OP_MUL, 8'h0C, 8'h0B);
        check("mul_ready_low", 8'(inReady), 8'd0);
        check("mul_no_ov0", 8'(outValid), 8'd0);
        opIn = 3'(OP_ADD);
        aIn  = 8'h01;
        bIn  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            inValid = i[0];
            step();
            check($sformatf("mul_busy_ready%0d", i), 8'(inReady), 8'd0);
            check($sformatf("mul_busy_ov%0d", i), 8'(outValid), 8'd0);
        end
        inValid = 1'b1;
        step();
        expectResult("mul_0c_0b", 8'h84, 4'b1000);
        check("mul_ready_back", 8'(inReady), 8'd1);
        inValid = 1'b0;
        step();
        check("mul_after_ov", 8'(outValid), 8'd0);
        check("mul_after_y", y, 8'h84);

        issue(OP_MUL, 8'h10, 8'h10);
        inValid = 1'b0;
        repeat (7) step();
        check("mul_zero_wait", 8'(outValid), 8'd0);
        step();
        expectResult("mul_zero", 8'h00, 4'b0100);

        // Back-to-back single-cycle ops with in_valid held high.
        issue(OP_ADD, 8'h10, 8'h20);
        expectResult("b2b_add", 8'h30, 4'b0000);
        issue(OP_XOR, 8'hFF, 8'h0F);
        expectResult("b2b_xor", 8'hF0, 4'b1000);
        issue(OP_OR, 8'h00, 8'h00);
        expectResult("b2b_or", 8'h00, 4'b0100);
        inValid = 1'b0;
        step();
        check("b2b_end_ov", 8'(outValid), 8'd0);

        // Reset in the middle of a multiply discards it.
        issue(OP_MUL, 8'hFF, 8'hFF);
        inValid = 1'b0;
        repeat (4) step();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_y", y, 8'h00);
        check("midrst_flags", 8'(flags), 8'h0);
        check("midrst_ov", 8'(outValid), 8'd0);
        check("midrst_ready", 8'(inReady), 8'd1);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("midrst_quiet%0d", i), 8'(outValid), 8'd0);
        end
        check("midrst_ready_after", 8'(inReady), 8'd1);
        issue(OP_ADD, 8'hFF, 8'h01);
        inValid = 1'b0;
        expectResult("add_wrap", 8'h00, 4'b0110);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
